// File: rtl/conv_shift_mac.sv
// Shift-add 3x3 convolution MAC: per-tap products from 4-bit shift/negate/zero codes,
// two-stage valid/ready pipeline (S1 products, S2 products + sum) with a transfer counter.
module conv_shift_mac #(
    parameter  int DATA_W = 4,
    parameter  int TAPS   = 9,
    localparam int PROD_W = DATA_W + 4,
    localparam int SUM_W  = PROD_W + $clog2(TAPS),
    localparam int AW     = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*DATA_W-1:0]   in_pix,
    input  logic                     coef_wr,
    input  logic [AW-1:0]            coef_addr,
    input  logic [3:0]               coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAPS*PROD_W-1:0]   out_prod,
    output logic [SUM_W-1:0]         out_sum,
    output logic [15:0]              win_count
);

    localparam logic [AW:0] TAPS_L = (AW+1)'(TAPS);

    logic [3:0]              coef_q [TAPS];
    logic                    v1_q, v2_q;
    logic [TAPS*PROD_W-1:0]  prod1_q, prod2_q;
    logic [SUM_W-1:0]        sum2_q;
    logic [15:0]             win_cnt_q;

    logic [TAPS*PROD_W-1:0]  prod_d;
    logic [SUM_W-1:0]        sum_d;
    logic                    s1_free, s2_free, accept, xfer_out, coef_hit;

    // Reset kernel is a Laplacian: centre +4, edge neighbours -1, corners 0.
    function automatic logic [3:0] reset_coef(input int k);
        if (k == TAPS / 2)
            return 4'b0010;
        else if (k % 2 == 1)
            return 4'b1000;
        else
            return 4'b0100;
    endfunction

    function automatic logic [PROD_W-1:0] tap_prod(input logic [DATA_W-1:0] pix,
                                                   input logic [3:0]        code);
        logic [PROD_W-1:0] mag;
        mag = PROD_W'(pix) << code[1:0];
        if (code[2])
            return '0;
        else if (code[3])
            return ~mag + PROD_W'(1);
        else
            return mag;
    endfunction

    assign s2_free   = !v2_q || out_ready;
    assign s1_free   = !v1_q || s2_free;
    assign in_ready  = enable && s1_free;
    assign accept    = in_valid && in_ready;
    assign xfer_out  = v2_q && out_ready;
    assign coef_hit  = coef_wr && ({1'b0, coef_addr} < TAPS_L);

    assign out_valid = v2_q;
    assign out_prod  = prod2_q;
    assign out_sum   = sum2_q;
    assign win_count = win_cnt_q;

    always_comb begin
        prod_d = '0;
        for (int k = 0; k < TAPS; k++)
            prod_d[k*PROD_W +: PROD_W] = tap_prod(in_pix[k*DATA_W +: DATA_W], coef_q[k]);
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++)
            sum_d = sum_d + {{(SUM_W-PROD_W){prod1_q[k*PROD_W+PROD_W-1]}},
                             prod1_q[k*PROD_W +: PROD_W]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            prod1_q   <= '0;
            prod2_q   <= '0;
            sum2_q    <= '0;
            win_cnt_q <= '0;
            for (int k = 0; k < TAPS; k++)
                coef_q[k] <= reset_coef(k);
        end else begin
            // Products already in S1 were computed with the coefficients of their
            // acceptance cycle, so a write here never disturbs in-flight windows.
            if (coef_hit)
                coef_q[coef_addr] <= coef_data;
            if (xfer_out)
                win_cnt_q <= win_cnt_q + 16'd1;
            if (!enable) begin
                v1_q    <= 1'b0;
                v2_q    <= 1'b0;
                prod1_q <= '0;
                prod2_q <= '0;
                sum2_q  <= '0;
            end else begin
                if (s2_free) begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        prod2_q <= prod1_q;
                        sum2_q  <= sum_d;
                    end
                end
                if (s1_free) begin
                    v1_q <= accept;
                    if (accept)
                        prod1_q <= prod_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_shift_mac.sv
// Scoreboard bench for conv_shift_mac: directed windows push hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_conv_shift_mac;

    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, in_ready, coef_wr, out_valid, out_ready;
    logic [35:0] in_pix;
    logic [3:0]  coef_addr, coef_data;
    logic [71:0] out_prod;
    logic [11:0] out_sum;
    logic [15:0] win_count;

    typedef struct {
        logic [71:0] p;
        logic [11:0] s;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] tb_xfers = '0;
    bit          bulk = 0;
    bit          saw_ready_low = 0;
    bit          hold_pend = 0;
    logic [71:0] held_p;
    logic [11:0] held_s;
    logic [35:0] ones = 36'h111111111;

    conv_shift_mac dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .in_pix(in_pix), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_sum(out_sum),
        .win_count(win_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    function automatic logic [71:0] mkp(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [35:0] pix, input logic [71:0] ep, input int es,
                        input bit push);
        int   n;
        exp_t e;
        in_pix   = pix;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready got 0, required 1");
        end else if (push) begin
            e.p = ep;
            e.s = 12'(es);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic [3:0] d);
        coef_wr   = 1'b1;
        coef_addr = a;
        coef_data = d;
        cyc(1);
        coef_wr   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (hold_pend) begin
            chk("stall_hold_valid", 72'(out_valid), 72'(1'b1));
            chk("stall_hold_prod", out_prod, held_p);
            chk("stall_hold_sum", 72'(out_sum), 72'(held_s));
        end
        hold_pend = 0;
        if (out_valid && !out_ready && enable && rst_n) begin
            hold_pend = 1;
            held_p    = out_prod;
            held_s    = out_sum;
        end
        if (out_valid && out_ready) begin
            tb_xfers = tb_xfers + 16'd1;
            if (!bulk) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got sum %h, required no output", out_sum);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_prod", out_prod, e.p);
                    chk("sb_sum", 72'(out_sum), 72'(e.s));
                end
            end
        end
        if (enable && !in_ready)
            saw_ready_low = 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_pix = '0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;

        // Reset state
        cyc(2);
        chk("rst_valid", 72'(out_valid), 72'(0));
        chk("rst_prod", out_prod, 72'(0));
        chk("rst_sum", 72'(out_sum), 72'(0));
        chk("rst_wincount", 72'(win_count), 72'(0));
        chk("rst_ready_en0", 72'(in_ready), 72'(0));
        enable = 1'b1;
        #1;
        chk("rst_ready_en1", 72'(in_ready), 72'(1));
        cyc(1);
        rst_n = 1'b1;

        // Laplacian, all pixels 3, plus latency
        send(36'h333333333, mkp(0, -3, 0, -3, 12, -3, 0, -3, 0), 0, 1);
        @(negedge clk);
        chk("lat_cycle1_valid", 72'(out_valid), 72'(0));
        @(negedge clk);
        chk("lat_cycle2_valid", 72'(out_valid), 72'(1));
        cyc(2);

        // Centre only, then everything but centre
        send(36'h0000F0000, mkp(0, 0, 0, 0, 60, 0, 0, 0, 0), 60, 1);
        send(36'hFFFF0FFFF, mkp(0, -15, 0, -15, 0, -15, 0, -15, 0), -60, 1);
        cyc(3);

        // Write tap0=+8 in the same cycle a window is accepted: that window uses old kernel
        coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 4'b0011;
        send(36'hFFFFFFFFF, mkp(0, -15, 0, -15, 60, -15, 0, -15, 0), 0, 1);
        coef_wr = 1'b0;
        send(36'hFFFFFFFFF, mkp(120, -15, 0, -15, 60, -15, 0, -15, 0), 120, 1);
        cyc(3);

        // Negate+shift, zero overriding negate, out-of-range addresses ignored
        wr_coef(4'd2, 4'b1001);
        wr_coef(4'd6, 4'b1111);
        wr_coef(4'd9, 4'b0011);
        wr_coef(4'd15, 4'b1011);
        send(ones, mkp(8, -1, -2, -1, 4, -1, 0, -1, 0), 6, 1);
        cyc(3);
        chk("wincount_a", 72'(win_count), 72'(tb_xfers));

        // Five back-to-back windows with a 3-cycle downstream stall
        saw_ready_low = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(36'(ones * 36'(k)),
                         mkp(8*k, -k, -2*k, -k, 4*k, -k, 0, -k, 0), 6*k, 1);
            end
            begin
                cyc(2);
                out_ready = 1'b0;
                cyc(3);
                out_ready = 1'b1;
            end
        join
        cyc(4);
        chk("stall_ready_dropped", 72'(saw_ready_low), 72'(1));
        chk("wincount_after_burst", 72'(win_count), 72'(11));
        chk("sb_empty_burst", 72'(sb_q.size()), 72'(0));

        // Drop enable with two windows in flight
        out_ready = 1'b0;
        send(36'h555555555, '0, 0, 0);
        send(36'h777777777, '0, 0, 0);
        enable = 1'b0;
        @(negedge clk);
        chk("flush_ready_low", 72'(in_ready), 72'(0));
        cyc(1);
        @(negedge clk);
        chk("flush_valid", 72'(out_valid), 72'(0));
        chk("flush_sum", 72'(out_sum), 72'(0));
        chk("flush_prod", out_prod, 72'(0));
        #1;
        enable = 1'b1;
        out_ready = 1'b1;
        cyc(4);
        chk("flush_wincount", 72'(win_count), 72'(11));
        send(ones, mkp(8, -1, -2, -1, 4, -1, 0, -1, 0), 6, 1);
        cyc(3);
        chk("wincount_pre_reset", 72'(win_count), 72'(12));
        chk("wincount_model", 72'(win_count), 72'(tb_xfers));

        // Reset mid-stream
        out_ready = 1'b0;
        send(36'h222222222, '0, 0, 0);
        send(36'h444444444, '0, 0, 0);
        rst_n = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("midrst_valid", 72'(out_valid), 72'(0));
        chk("midrst_prod", out_prod, 72'(0));
        chk("midrst_sum", 72'(out_sum), 72'(0));
        chk("midrst_wincount", 72'(win_count), 72'(0));
        chk("midrst_ready_eq_en", 72'(in_ready), 72'(1));
        tb_xfers = '0;
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(1);
        send(36'h333333333, mkp(0, -3, 0, -3, 12, -3, 0, -3, 0), 0, 1);
        cyc(3);
        chk("post_rst_wincount", 72'(win_count), 72'(1));

        // Stream to 0xFFFF transfers, then one more wraps to zero
        bulk = 1;
        in_pix = '0;
        in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc(4);
        bulk = 0;
        chk("wincount_ffff", 72'(win_count), 72'(16'hFFFF));
        chk("wincount_ffff_model", 72'(win_count), 72'(tb_xfers));
        send(36'h333333333, mkp(0, -3, 0, -3, 12, -3, 0, -3, 0), 0, 1);
        cyc(4);
        chk("wincount_wrap", 72'(win_count), 72'(0));
        chk("sb_empty_end", 72'(sb_q.size()), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
